// File: rtl/lcd_debug_pkg.sv
// Shared constants and helpers for the LCD debug-screen character generator:
// header text, blank/heart codes, cell classes and nybble-to-ASCII conversion.
package lcd_debug_pkg;

    localparam logic [6:0] CHAR_SPACE = 7'h20;
    localparam logic [6:0] CHAR_HEART = 7'h03;
    localparam logic [6:0] CHAR_FOUR  = 7'h34;

    localparam logic [6:0] HDR_CHAR_0 = 7'h41;  // 'A'
    localparam logic [6:0] HDR_CHAR_1 = 7'h6C;  // 'l'
    localparam logic [6:0] HDR_CHAR_2 = 7'h69;  // 'i'
    localparam logic [6:0] HDR_CHAR_3 = 7'h63;  // 'c'
    localparam logic [6:0] HDR_CHAR_4 = 7'h65;  // 'e'

    localparam logic [3:0] HDR_COL_FOUR  = 4'd6;
    localparam logic [3:0] HDR_COL_HEART = 4'd8;
    localparam int         HDR_MAX_COL   = 15;

    typedef enum logic [1:0] {
        CELL_BLANK  = 2'd0,
        CELL_HEADER = 2'd1,
        CELL_DIGIT  = 2'd2
    } cell_class_e;

    function automatic logic [6:0] nybble_to_ascii(input logic [3:0] nyb);
        if (nyb < 4'd10) begin
            return 7'h30 + {3'b000, nyb};
        end
        return 7'h37 + {3'b000, nyb};
    endfunction

    function automatic logic [6:0] header_char(input logic [3:0] col);
        logic [6:0] ch;
        case (col)
            4'd0:          ch = HDR_CHAR_0;
            4'd1:          ch = HDR_CHAR_1;
            4'd2:          ch = HDR_CHAR_2;
            4'd3:          ch = HDR_CHAR_3;
            4'd4:          ch = HDR_CHAR_4;
            HDR_COL_FOUR:  ch = CHAR_FOUR;
            HDR_COL_HEART: ch = CHAR_HEART;
            default:       ch = CHAR_SPACE;
        endcase
        return ch;
    endfunction

    // Hold counters need to reach HOLD_FRAMES; keep at least one bit when disabled.
    function automatic int count_bits(input int hold);
        if (hold > 0) begin
            return $clog2(hold + 1);
        end
        return 1;
    endfunction

endpackage

// File: rtl/lcd_debug_snapshot.sv
// Per-frame snapshot of the displayed registers plus per-nybble change
// highlighting that decays after a fixed number of unchanged frames.
module lcd_debug_snapshot
    import lcd_debug_pkg::*;
#(
    parameter int NUM_VALUES  = 3,
    parameter int VALUE_WIDTH = 32,
    parameter int HOLD_FRAMES = 30
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic                                 frame_start,
    input  logic [NUM_VALUES*VALUE_WIDTH-1:0]     values,
    output logic [NUM_VALUES*VALUE_WIDTH-1:0]     shadow,
    output logic [NUM_VALUES*(VALUE_WIDTH/4)-1:0] mask
);

    localparam int N  = VALUE_WIDTH / 4;
    localparam int CW = count_bits(HOLD_FRAMES);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_FRAMES);

    genvar gi, gn;
    for (gi = 0; gi < NUM_VALUES; gi++) begin : g_value
        logic [VALUE_WIDTH-1:0] cur;
        logic [VALUE_WIDTH-1:0] shadow_q, shadow_d;
        logic [N-1:0]           diff;
        logic [N-1:0]           mask_q, mask_d;
        logic [CW-1:0]          count_q, count_d;

        assign cur = values[gi*VALUE_WIDTH +: VALUE_WIDTH];

        for (gn = 0; gn < N; gn++) begin : g_nyb
            assign diff[gn] = |(cur[gn*4 +: 4] ^ shadow_q[gn*4 +: 4]);
        end

        always_comb begin
            shadow_d = shadow_q;
            mask_d   = mask_q;
            count_d  = count_q;
            if (frame_start) begin
                shadow_d = cur;
                if (HOLD_FRAMES > 0) begin
                    // A fresh change restarts the hold; the mask only clears
                    // once the full hold has elapsed without any change.
                    if (|diff) begin
                        mask_d  = mask_q | diff;
                        count_d = HOLD_LOAD;
                    end else if (count_q > CW'(1)) begin
                        count_d = count_q - CW'(1);
                    end else if (count_q == CW'(1)) begin
                        count_d = '0;
                        mask_d  = '0;
                    end
                end
            end
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                shadow_q <= '0;
                mask_q   <= '0;
                count_q  <= '0;
            end else begin
                shadow_q <= shadow_d;
                mask_q   <= mask_d;
                count_q  <= count_d;
            end
        end

        assign shadow[gi*VALUE_WIDTH +: VALUE_WIDTH] = shadow_q;
        assign mask[gi*N +: N]                       = mask_q;
    end

endmodule

// File: rtl/lcd_debug_grid.sv
// Debug-screen character generator: maps a (column, row) lookup to a character
// code and inverse flag through a fixed two-stage pipeline.
module lcd_debug_grid
    import lcd_debug_pkg::*;
#(
    parameter int NUM_VALUES    = 3,
    parameter int VALUE_WIDTH   = 32,
    parameter int FIRST_ROW     = 2,
    parameter int GROUP_NIBBLES = 4,
    parameter int HOLD_FRAMES   = 30
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             frame_start,
    input  logic [NUM_VALUES*VALUE_WIDTH-1:0] values,
    input  logic                             lookup,
    input  logic [6:0]                       column,
    input  logic [5:0]                       row,
    output logic [6:0]                       character,
    output logic                             inverse,
    output logic                             char_valid
);

    localparam int N      = VALUE_WIDTH / 4;
    localparam int G1     = GROUP_NIBBLES + 1;
    localparam int LINE_W = N + (N - 1) / GROUP_NIBBLES;
    localparam int TOTAL  = NUM_VALUES * N;
    localparam int KW     = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int SLOTS  = 1 << KW;
    localparam logic [6:0] ROW_LO = 7'(FIRST_ROW);
    localparam logic [6:0] ROW_HI = 7'(FIRST_ROW + NUM_VALUES);

    logic [NUM_VALUES*VALUE_WIDTH-1:0] shadow;
    logic [TOTAL-1:0]                  mask;

    lcd_debug_snapshot #(
        .NUM_VALUES  (NUM_VALUES),
        .VALUE_WIDTH (VALUE_WIDTH),
        .HOLD_FRAMES (HOLD_FRAMES)
    ) u_snapshot (
        .clock       (clock),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .values      (values),
        .shadow      (shadow),
        .mask        (mask)
    );

    // Flat nybble table indexed by value*N + nybble, padded to a power of two
    // so the select index can never point outside the table.
    logic [3:0]       nyb_tab [SLOTS];
    logic [SLOTS-1:0] mask_tab;

    genvar gi;
    for (gi = 0; gi < SLOTS; gi++) begin : g_slot
        if (gi < TOTAL) begin : g_used
            assign nyb_tab[gi]  = shadow[gi*4 +: 4];
            assign mask_tab[gi] = mask[gi];
        end else begin : g_pad
            assign nyb_tab[gi]  = 4'h0;
            assign mask_tab[gi] = 1'b0;
        end
    end

    logic [7:0]  col_w;
    logic [7:0]  digit_idx;
    logic [7:0]  nib_pos;
    logic [6:0]  row_w;
    logic [6:0]  vidx;
    logic [KW-1:0] slot;
    logic        is_gap;
    logic        in_line;
    logic        is_value_row;
    cell_class_e cls;

    always_comb begin
        col_w        = {1'b0, column};
        row_w        = {1'b0, row};
        is_gap       = ((col_w + 8'd1) % 8'(G1)) == 8'd0;
        in_line      = col_w < 8'(LINE_W);
        digit_idx    = col_w - col_w / 8'(G1);
        nib_pos      = 8'(N - 1) - digit_idx;
        is_value_row = (row_w >= ROW_LO) && (row_w < ROW_HI);
        vidx         = row_w - ROW_LO;
        slot         = KW'(16'(vidx) * 16'(N) + 16'(nib_pos));
        cls          = CELL_BLANK;
        if (row == 6'd0) begin
            if (column <= 7'(HDR_MAX_COL)) begin
                cls = CELL_HEADER;
            end
        end else if (is_value_row && in_line && !is_gap) begin
            cls = CELL_DIGIT;
        end
    end

    // Stage 1 captures the shadow nybble and mask bit now, so a lookup in the
    // same cycle as frame_start still sees the pre-update snapshot.
    logic        s1_valid_q, s1_valid_d;
    cell_class_e s1_class_q, s1_class_d;
    logic [3:0]  s1_nyb_q, s1_nyb_d;
    logic        s1_inv_q, s1_inv_d;
    logic [3:0]  s1_hcol_q, s1_hcol_d;

    always_comb begin
        s1_valid_d = lookup;
        s1_class_d = cls;
        s1_nyb_d   = nyb_tab[slot];
        s1_inv_d   = mask_tab[slot] && (cls == CELL_DIGIT);
        s1_hcol_d  = column[3:0];
    end

    logic [6:0] character_q, character_d;
    logic       inverse_q, inverse_d;
    logic       char_valid_q, char_valid_d;

    always_comb begin
        character_d  = character_q;
        inverse_d    = inverse_q;
        char_valid_d = s1_valid_q;
        if (s1_valid_q) begin
            case (s1_class_q)
                CELL_DIGIT: begin
                    character_d = nybble_to_ascii(s1_nyb_q);
                    inverse_d   = s1_inv_q;
                end
                CELL_HEADER: begin
                    character_d = header_char(s1_hcol_q);
                    inverse_d   = 1'b0;
                end
                default: begin
                    character_d = CHAR_SPACE;
                    inverse_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q   <= 1'b0;
            s1_class_q   <= CELL_BLANK;
            s1_nyb_q     <= 4'h0;
            s1_inv_q     <= 1'b0;
            s1_hcol_q    <= 4'h0;
            character_q  <= CHAR_SPACE;
            inverse_q    <= 1'b0;
            char_valid_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_class_q   <= s1_class_d;
            s1_nyb_q     <= s1_nyb_d;
            s1_inv_q     <= s1_inv_d;
            s1_hcol_q    <= s1_hcol_d;
            character_q  <= character_d;
            inverse_q    <= inverse_d;
            char_valid_q <= char_valid_d;
        end
    end

    assign character  = character_q;
    assign inverse    = inverse_q;
    assign char_valid = char_valid_q;

endmodule
